// File: rtl/uart_cell_ctrl.sv
// Write-port scheduler for the 2x4 cell matrix: row-major byte fill, host commands,
// a sequenced eight-cell clear with a 1-deep pending byte buffer, and error counting.
module uart_cell_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [W-1:0] rx_data,
  input  logic         rx_err,
  input  logic [3:0]   action,
  input  logic         action_valid,
  output logic         action_ack,
  output logic         busy,
  output logic         wr_en,
  output logic         wr_row,
  output logic [1:0]   wr_col,
  output logic [W-1:0] wr_data,
  output logic         ptr_row,
  output logic [1:0]   ptr_col,
  output logic         frame_done,
  output logic         armed,
  output logic         overflow,
  output logic [3:0]   err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAIN
  } state_t;

  localparam logic [3:0] ACT_RESET_PTR = 4'h1;
  localparam logic [3:0] ACT_CLEAR     = 4'h2;
  localparam logic [3:0] ACT_SKIP      = 4'h3;
  localparam logic [3:0] ACT_ARM       = 4'h4;
  localparam logic [3:0] ACT_DISARM    = 4'h5;

  state_t         state;
  logic [2:0]     ptr;
  logic [3:0]     clr_idx;
  logic           pend_valid;
  logic [W-1:0]   pend_data;

  logic           byte_ok;
  logic           err_byte;
  logic           pend_next_valid;
  logic [W-1:0]   pend_next_data;

  assign ptr_row = ptr[2];
  assign ptr_col = ptr[1:0];

  always_comb begin
    byte_ok         = rx_valid && !rx_err && armed;
    err_byte        = rx_valid && rx_err;
    // Buffer contents after this cycle's capture; lets the last clear cycle
    // hand a just-arrived byte straight to the drain write.
    pend_next_valid = pend_valid || byte_ok;
    pend_next_data  = pend_valid ? pend_data : rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      clr_idx    <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      action_ack <= 1'b0;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      wr_row     <= 1'b0;
      wr_col     <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      armed      <= 1'b1;
      overflow   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      action_ack <= 1'b0;

      if (err_byte && err_cnt != 4'hF) begin
        err_cnt <= err_cnt + 4'd1;
      end

      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            if (byte_ok) begin
              wr_en      <= 1'b1;
              wr_row     <= ptr[2];
              wr_col     <= ptr[1:0];
              wr_data    <= rx_data;
              frame_done <= (ptr == 3'd7);
              ptr        <= ptr + 3'd1;
            end
          end else if (action_valid) begin
            action_ack <= 1'b1;
            case (action)
              ACT_RESET_PTR: ptr <= '0;
              ACT_CLEAR: begin
                state   <= S_CLEAR;
                busy    <= 1'b1;
                wr_en   <= 1'b1;
                wr_row  <= 1'b0;
                wr_col  <= '0;
                wr_data <= '0;
                clr_idx <= 4'd1;
              end
              ACT_SKIP:   ptr <= ptr + 3'd1;
              ACT_ARM: begin
                armed    <= 1'b1;
                overflow <= 1'b0;
              end
              ACT_DISARM: armed <= 1'b0;
              default: ;
            endcase
          end
        end

        S_CLEAR: begin
          if (byte_ok) begin
            if (pend_valid) begin
              overflow <= 1'b1;
            end else begin
              pend_valid <= 1'b1;
              pend_data  <= rx_data;
            end
          end

          if (clr_idx < 4'd8) begin
            wr_en   <= 1'b1;
            wr_row  <= clr_idx[2];
            wr_col  <= clr_idx[1:0];
            wr_data <= '0;
            clr_idx <= clr_idx + 4'd1;
          end else if (pend_next_valid) begin
            // The buffer stays full through DRAIN so a byte arriving then overflows.
            state   <= S_DRAIN;
            wr_en   <= 1'b1;
            wr_row  <= 1'b0;
            wr_col  <= '0;
            wr_data <= pend_next_data;
            ptr     <= 3'd1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
          end
        end

        S_DRAIN: begin
          if (byte_ok) begin
            overflow <= 1'b1;
          end
          pend_valid <= 1'b0;
          state      <= S_IDLE;
          busy       <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cell_ctrl.sv
// Directed bench for uart_cell_ctrl: fill order, error counting, clear with pending
// byte and overflow, command priority, arm/disarm, skip wrap and reset mid-clear.
module tb_uart_cell_ctrl;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic [3:0] action;
  logic       action_valid;
  logic       action_ack;
  logic       busy;
  logic       wr_en;
  logic       wr_row;
  logic [1:0] wr_col;
  logic [7:0] wr_data;
  logic       ptr_row;
  logic [1:0] ptr_col;
  logic       frame_done;
  logic       armed;
  logic       overflow;
  logic [3:0] err_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  uart_cell_ctrl #(.W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_err       (rx_err),
    .action       (action),
    .action_valid (action_valid),
    .action_ack   (action_ack),
    .busy         (busy),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_data      (wr_data),
    .ptr_row      (ptr_row),
    .ptr_col      (ptr_col),
    .frame_done   (frame_done),
    .armed        (armed),
    .overflow     (overflow),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pointer as a row-major index 0..7.
  function automatic logic [31:0] ptr_idx();
    return {29'd0, ptr_row, ptr_col};
  endfunction

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_err = 1'b0;
    action = '0; action_valid = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_armed", armed, 1);
    chk("rst_ptr", ptr_idx(), 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ack", action_ack, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    step();

    // Eight back-to-back bytes fill (0,0)..(1,3)
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(8'h11 * (i + 1));
      step();
      chk("fill_wr_en", wr_en, 1);
      chk("fill_cell", {wr_row, wr_col}, i);
      chk("fill_data", wr_data, 8'h11 * (i + 1));
      chk("fill_frame_done", frame_done, (i == 7) ? 1 : 0);
      chk("fill_ptr", ptr_idx(), (i + 1) % 8);
    end
    rx_valid = 1'b0;
    step();
    chk("fill_idle_wr_en", wr_en, 0);
    chk("fill_hold_data", wr_data, 8'h88);
    chk("fill_hold_cell", {wr_row, wr_col}, 7);
    chk("fill_frame_low", frame_done, 0);

    // Three bytes, then sixteen errored bytes
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(i + 1);
      step();
    end
    chk("three_ptr", ptr_idx(), 3);
    rx_err = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rx_data = 8'hE0;
      step();
      chk("err_no_write", wr_en, 0);
      chk("err_cnt", err_cnt, (k + 1 > 15) ? 15 : k + 1);
    end
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    step();
    chk("err_ptr", ptr_idx(), 3);
    chk("err_cnt_sat", err_cnt, 15);

    // CLEAR with bytes at t+3 and t+5
    action = 4'h2;
    action_valid = 1'b1;
    step();
    chk("clr_ack", action_ack, 1);
    for (int c = 1; c <= 8; c++) begin
      chk("clr_busy", busy, 1);
      chk("clr_wr_en", wr_en, 1);
      chk("clr_cell", {wr_row, wr_col}, c - 1);
      chk("clr_data", wr_data, 0);
      chk("clr_frame_done", frame_done, 0);
      if (c > 1) chk("clr_ack_low", action_ack, 0);
      action_valid = 1'b0;
      rx_valid = (c == 3 || c == 5);
      rx_data  = (c == 3) ? 8'h5A : 8'h6B;
      step();
    end
    rx_valid = 1'b0;
    chk("drain_busy", busy, 1);
    chk("drain_wr_en", wr_en, 1);
    chk("drain_cell", {wr_row, wr_col}, 0);
    chk("drain_data", wr_data, 8'h5A);
    chk("drain_overflow", overflow, 1);
    chk("drain_ptr", ptr_idx(), 1);
    chk("drain_frame_done", frame_done, 0);
    step();
    chk("post_clr_busy", busy, 0);
    chk("post_clr_wr_en", wr_en, 0);
    chk("post_clr_ptr", ptr_idx(), 1);
    chk("post_clr_err_cnt", err_cnt, 15);

    // Byte and RESET_PTR in the same cycle
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    action   = 4'h1;
    action_valid = 1'b1;
    step();
    chk("prio_wr_en", wr_en, 1);
    chk("prio_cell", {wr_row, wr_col}, 1);
    chk("prio_data", wr_data, 8'h77);
    chk("prio_no_ack", action_ack, 0);
    chk("prio_ptr", ptr_idx(), 2);
    rx_valid = 1'b0;
    step();
    chk("prio_ack", action_ack, 1);
    chk("prio_ptr_reset", ptr_idx(), 0);
    chk("prio_no_write", wr_en, 0);
    action_valid = 1'b0;
    step();
    chk("prio_ack_pulse", action_ack, 0);

    // DISARM drops bytes, ARM clears overflow
    action = 4'h5;
    action_valid = 1'b1;
    step();
    chk("disarm_ack", action_ack, 1);
    chk("disarm_armed", armed, 0);
    action_valid = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    step();
    chk("disarm_no_write", wr_en, 0);
    chk("disarm_overflow", overflow, 1);
    chk("disarm_ptr", ptr_idx(), 0);
    rx_valid = 1'b0;
    action = 4'h4;
    action_valid = 1'b1;
    step();
    chk("arm_ack", action_ack, 1);
    chk("arm_armed", armed, 1);
    chk("arm_overflow", overflow, 0);
    action_valid = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    step();
    chk("arm_wr_en", wr_en, 1);
    chk("arm_cell", {wr_row, wr_col}, 0);
    chk("arm_data", wr_data, 8'h44);
    chk("arm_ptr", ptr_idx(), 1);
    rx_valid = 1'b0;

    // SKIP held for seven cycles wraps 1 -> 0 without writes or frame_done
    action = 4'h3;
    action_valid = 1'b1;
    for (int s = 0; s < 7; s++) begin
      step();
      chk("skip_ack", action_ack, 1);
      chk("skip_ptr", ptr_idx(), (2 + s) % 8);
      chk("skip_no_write", wr_en, 0);
      chk("skip_frame", frame_done, 0);
    end

    // Unknown code: acked, no effect
    action = 4'hF;
    step();
    chk("unk_ack", action_ack, 1);
    chk("unk_ptr", ptr_idx(), 0);
    chk("unk_armed", armed, 1);
    chk("unk_busy", busy, 0);

    // Reset during CLEAR
    action = 4'h5;
    step();
    chk("pre_rst_armed", armed, 0);
    action = 4'h3;
    step();
    chk("pre_rst_ptr", ptr_idx(), 1);
    action = 4'h2;
    step();
    chk("rclr_busy", busy, 1);
    action_valid = 1'b0;
    step();
    step();
    step();
    chk("rclr_t4_cell", {wr_row, wr_col}, 3);
    rst = 1'b1;
    #1;
    chk("rclr_busy", busy, 0);
    chk("rclr_wr_en", wr_en, 0);
    chk("rclr_ptr", ptr_idx(), 0);
    chk("rclr_armed", armed, 1);
    chk("rclr_err_cnt", err_cnt, 0);
    step();
    rst = 1'b0;
    for (int q = 0; q < 6; q++) begin
      step();
      chk("rclr_no_write", wr_en, 0);
      chk("rclr_idle", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cell_ctrl.md
# uart_cell_ctrl

Write-port scheduler for the 2x4 cell matrix fed by the UART receiver. It shares the single matrix write port between two requesters: the received-byte stream, which fills cells in row-major order with an auto-incrementing pointer, and host action commands (pointer reset, skip, arm/disarm, bulk clear). It also sequences the multi-cycle clear and counts parity-errored bytes.

## Interface
- W, 8, cell/data width
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- rx_valid  input  1  one-cycle strobe: received byte available
- rx_data  input  W  received byte, valid with rx_valid
- rx_err  input  1  parity/framing error for the byte, valid with rx_valid
- action  input  4  host command code
- action_valid  input  1  command request, held until action_ack
- action_ack  output  1  one-cycle pulse: command accepted
- busy  output  1  clear sequence or pending-byte drain in progress
- wr_en  output  1  matrix write strobe
- wr_row  output  1  write row
- wr_col  output  2  write column
- wr_data  output  W  write data
- ptr_row  output  1  current fill pointer row
- ptr_col  output  2  current fill pointer column
- frame_done  output  1  one-cycle pulse with the write to cell (1,3)
- armed  output  1  byte capture enabled
- overflow  output  1  sticky: byte dropped because the pending buffer was full
- err_cnt  output  4  saturating count of rx_err bytes

## Operation
- States: IDLE, CLEAR, DRAIN. All outputs are registered.
- Reset values: all outputs 0 except armed=1; pointer (0,0); pending buffer empty.
- Actions, decoded only in IDLE with no rx_valid that cycle:
  - 0x1 RESET_PTR: pointer to (0,0).
  - 0x2 CLEAR: enter CLEAR.
  - 0x3 SKIP: advance the pointer without writing.
  - 0x4 ARM: armed=1 and overflow=0.
  - 0x5 DISARM: armed=0.
  - Other codes: acked, no effect.
- Pointer advance is row-major: (0,0)..(0,3),(1,0)..(1,3), then wraps to (0,0). SKIP past (1,3) wraps without a frame_done pulse.
- Byte in IDLE with armed=1 and rx_err=0: write rx_data at the pointer, then advance the pointer.
- Byte with rx_err=1: not written, pointer unchanged, err_cnt+1 saturating at 15. This applies whether or not armed.
- Byte with armed=0 and rx_err=0: dropped silently.
- Priority: rx_valid wins over action_valid in the same IDLE cycle. The action is not acked and must stay asserted.
- CLEAR: eight consecutive writes of 0 to cells (0,0)..(1,3) in order. Then the pointer goes to (0,0). No frame_done pulse during CLEAR.
- During CLEAR, a valid armed byte goes to the 1-deep pending buffer. A second such byte while the buffer is full is dropped and sets overflow. err_cnt still counts errored bytes during CLEAR.
- After CLEAR: go to DRAIN if the buffer is full, otherwise IDLE.
- DRAIN: write the pending byte at (0,0), advance the pointer, return to IDLE. A byte arriving in the DRAIN cycle is treated as a CLEAR-time byte.
- Asynchronous reset mid-CLEAR or mid-DRAIN aborts immediately to reset values. Partially cleared cells are left as-is.

## Timing
- Byte accepted at cycle t: wr_en=1 at t+1 with row/col equal to the pointer value at t. The pointer shows the advanced value at t+1. frame_done=1 at t+1 when the written cell is (1,3).
- Action accepted at t: action_ack=1 at t+1 and its effect is visible at t+1.
- CLEAR accepted at t: busy=1 for cycles t+1..t+8 (plus t+9 if DRAIN). wr_en=1 for t+1..t+8 with wr_data=0. Pending byte written at t+9.
- Back-to-back bytes (rx_valid on consecutive cycles) are sustained at one write per cycle.
- wr_en is low in every cycle not listed above. wr_row/wr_col/wr_data hold their last values when wr_en is low.

## Test plan
- Reset, then 8 bytes 0x11..0x88 one per cycle -> writes to (0,0)..(1,3) in order; frame_done only with the 0x88 write; pointer (0,0).
- After 3 bytes, bytes with rx_err=1, 16 times -> no writes; err_cnt saturates at 15; pointer stays (0,3).
- CLEAR at t, byte 0x5A at t+3, byte 0x6B at t+5 -> zero writes t+1..t+8; 0x5A written at (0,0) on t+9; overflow=1; pointer (0,1).
- action_valid with RESET_PTR in the same cycle as rx_valid -> byte written, no ack; ack the following cycle; pointer (0,0).
- DISARM, byte 0x33 -> no write, overflow unchanged; ARM then byte -> written at the current pointer.
- Assert rst at cycle t+4 of CLEAR -> busy=0, wr_en=0, pointer (0,0), armed=1 immediately; no further writes.
